// File: rtl/spike_frame_tx.sv
// Serializes each captured 96-neuron spike vector as a 14-byte framed packet (header, 12 data, XOR checksum).
// Capture to first byte: 1 cycle; per byte: 2*(SYNC_STAGES+1) cycles minimum with an instant host.
// Four-phase valid/ack with the host; spike vectors arriving mid-frame are dropped and counted.
module spike_frame_tx #(
  parameter int N_NEURONS   = 96,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_NEURONS-1:0] spike_vec,
  input  logic                 spike_valid,
  input  logic                 tx_ack,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 frame_busy,
  output logic                 overrun,
  output logic [7:0]           drop_cnt
);

  localparam int NBYTES = N_NEURONS / 8;
  localparam int LAST   = NBYTES + 1;
  localparam int IDX_W  = $clog2(LAST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_WAIT_LOW} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [3:0]             seq_q, seq_d;
  logic [N_NEURONS-1:0]   shadow_q, shadow_d;
  logic [7:0]             data_q, data_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;
  logic [7:0]             csum;

  logic ack_s;
  logic capture_idle;
  logic byte_done;
  logic last_done;
  logic capture_bnd;
  logic drop;

  // Byte k of the frame: header at 0, checksum at the last index, shadow bytes between.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] k,
                                            input logic [3:0] sq,
                                            input logic [N_NEURONS-1:0] sh,
                                            input logic [7:0] cs);
    logic [7:0] b;
    b = 8'h00;
    if (k == '0) begin
      b = {4'hA, sq};
    end else if (k == LAST_IDX) begin
      b = cs;
    end else begin
      for (int i = 1; i <= NBYTES; i++) begin
        if (k == IDX_W'(i)) b = sh[8*i-8 +: 8];
      end
    end
    return b;
  endfunction

  assign ack_s        = ack_sync_q[SYNC_STAGES-1];
  assign capture_idle = (state_q == S_IDLE) && spike_valid && ena;
  assign byte_done    = (state_q == S_WAIT_LOW) && !ack_s;
  assign last_done    = byte_done && (idx_q == LAST_IDX);
  // A new vector landing exactly as the last byte completes starts the next frame instead of being dropped.
  assign capture_bnd  = last_done && spike_valid && ena;
  assign drop         = spike_valid && (state_q != S_IDLE) && !capture_bnd;

  // Checksum over the data bytes of the frame in flight.
  always_comb begin
    csum = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      csum = csum ^ shadow_q[8*i +: 8];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (spike_valid && ena) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (ack_s) state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!ack_s) begin
          if (idx_q != LAST_IDX)  state_d = S_PRESENT;
          else if (capture_bnd)   state_d = S_PRESENT;
          else                    state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    tx_valid   = 1'b0;
    frame_busy = 1'b0;
    case (state_q)
      S_PRESENT:  begin tx_valid = 1'b1; frame_busy = 1'b1; end
      S_WAIT_LOW: begin frame_busy = 1'b1; end
      default:    begin end
    endcase
  end

  // Datapath next state: synchronizer, frame index/byte, sequence number and drop accounting.
  always_comb begin
    ack_sync_d    = ack_sync_q;
    ack_sync_d[0] = tx_ack;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ack_sync_d[i] = ack_sync_q[i-1];
    end

    idx_d      = idx_q;
    seq_d      = seq_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;

    if (last_done) seq_d = seq_q + 4'd1;

    if (capture_idle) begin
      shadow_d = spike_vec;
      idx_d    = '0;
      data_d   = {4'hA, seq_q};
    end else if (capture_bnd) begin
      shadow_d = spike_vec;
      idx_d    = '0;
      data_d   = {4'hA, seq_q + 4'd1};
    end else if (byte_done && !last_done) begin
      idx_d  = idx_q + IDX_W'(1);
      data_d = frame_byte(idx_q + IDX_W'(1), seq_q, shadow_q, csum);
    end

    if (drop) begin
      overrun_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
      idx_q      <= '0;
      seq_q      <= 4'd0;
      shadow_q   <= '0;
      data_q     <= 8'h00;
      overrun_q  <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      ack_sync_q <= ack_sync_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      shadow_q   <= shadow_d;
      data_q     <= data_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign tx_data  = data_q;
  assign overrun  = overrun_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_spike_frame_tx.sv
// Directed bench for spike_frame_tx: acts as the host side of the four-phase handshake.
// Inputs driven and outputs sampled on the falling clock edge.
// Expected bytes are hand-computed constants.
module tb_spike_frame_tx;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [95:0] spike_vec;
  logic        spike_valid;
  logic        tx_ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        frame_busy;
  logic        overrun;
  logic [7:0]  drop_cnt;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] f0 [14] = '{8'hA0, 8'h33, 8'h22, 8'h11, 8'h00, 8'hEF, 8'hCD,
                          8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00};
  logic [95:0] vec0 = 96'h0123_4567_89AB_CDEF_0011_2233;

  spike_frame_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .spike_vec   (spike_vec),
    .spike_valid (spike_valid),
    .tx_ack      (tx_ack),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .frame_busy  (frame_busy),
    .overrun     (overrun),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host side of one byte: wait for valid, check it, 3 cycles ack high, 3 cycles ack low.
  task automatic recv_byte(input logic [7:0] exp, input string tag);
    int n = 0;
    while (tx_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, {31'd0, tx_valid}, 32'd1);
    chk(tag, {24'd0, tx_data}, {24'd0, exp});
    tx_ack = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk({tag, "_hold"}, {24'd0, tx_data}, {24'd0, exp});
    chk({tag, "_vld_drop"}, {31'd0, tx_valid}, 32'd0);
    tx_ack = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
  endtask

  task automatic pulse_valid(input logic [95:0] v);
    spike_vec   = v;
    spike_valid = 1'b1;
    @(negedge clk);
    spike_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_valid"},   {31'd0, tx_valid},   32'd0);
    chk({tag, "_tx_data"},    {24'd0, tx_data},    32'd0);
    chk({tag, "_frame_busy"}, {31'd0, frame_busy}, 32'd0);
    chk({tag, "_overrun"},    {31'd0, overrun},    32'd0);
    chk({tag, "_drop_cnt"},   {24'd0, drop_cnt},   32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    ena         = 1'b0;
    spike_vec   = '0;
    spike_valid = 1'b0;
    tx_ack      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Enable gating: spike_valid with ena low in IDLE does nothing.
    pulse_valid(vec0);
    repeat (3) @(negedge clk);
    chk("gate_tx_valid",   {31'd0, tx_valid},   32'd0);
    chk("gate_frame_busy", {31'd0, frame_busy}, 32'd0);
    chk("gate_drop_cnt",   {24'd0, drop_cnt},   32'd0);

    // Single frame with three drops while frame 0 is presenting its header.
    ena = 1'b1;
    pulse_valid(vec0);
    chk("cap_tx_valid",   {31'd0, tx_valid},   32'd1);
    chk("cap_tx_data",    {24'd0, tx_data},    32'hA0);
    chk("cap_frame_busy", {31'd0, frame_busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      pulse_valid({3{$urandom}});
      @(negedge clk);
    end
    chk("ovr_overrun",  {31'd0, overrun},  32'd1);
    chk("ovr_drop_cnt", {24'd0, drop_cnt}, 32'd3);
    spike_vec = {3{$urandom}};
    for (int k = 0; k < 14; k++) recv_byte(f0[k], $sformatf("f0_b%0d", k));
    chk("f0_busy_end", {31'd0, frame_busy}, 32'd0);
    chk("f0_drop_cnt", {24'd0, drop_cnt},   32'd3);

    // Stalled host at byte 5, ena dropped mid-frame, then reset.
    pulse_valid(vec0);
    ena = 1'b0;
    recv_byte(8'hA1, "st_b0");
    for (int k = 1; k < 5; k++) recv_byte(f0[k], $sformatf("st_b%0d", k));
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("stall_data_%0d", i),  {24'd0, tx_data},  32'hEF);
      chk($sformatf("stall_valid_%0d", i), {31'd0, tx_valid}, 32'd1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    ena = 1'b1;

    // Boundary acceptance at the last WAIT_LOW -> IDLE transition.
    pulse_valid('0);
    recv_byte(8'hA0, "bd_b0");
    for (int k = 1; k < 13; k++) recv_byte(8'h00, $sformatf("bd_b%0d", k));
    begin
      int n = 0;
      while (tx_valid !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bd_b13", {24'd0, tx_data}, 32'h00);
    tx_ack = 1'b1;
    repeat (3) @(negedge clk);
    tx_ack = 1'b0;
    repeat (2) @(negedge clk);
    pulse_valid('0);
    chk("bd_next_valid", {31'd0, tx_valid},   32'd1);
    chk("bd_next_hdr",   {24'd0, tx_data},    32'hA1);
    chk("bd_next_busy",  {31'd0, frame_busy}, 32'd1);
    chk("bd_drop_cnt",   {24'd0, drop_cnt},   32'd0);
    chk("bd_overrun",    {31'd0, overrun},    32'd0);
    recv_byte(8'hA1, "bd2_b0");
    for (int k = 1; k < 14; k++) recv_byte(8'h00, $sformatf("bd2_b%0d", k));

    // Sequence wrap over 17 all-zero frames from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 17; f++) begin
      pulse_valid('0);
      recv_byte(8'hA0 | 8'(f % 16), $sformatf("wr%0d_hdr", f));
      for (int k = 1; k < 14; k++) recv_byte(8'h00, $sformatf("wr%0d_b%0d", f, k));
    end

    // Drop counter saturation with the host stalled on the header.
    pulse_valid('0);
    spike_valid = 1'b1;
    repeat (200) @(negedge clk);
    chk("sat_200", {24'd0, drop_cnt}, 32'd200);
    repeat (100) @(negedge clk);
    spike_valid = 1'b0;
    @(negedge clk);
    chk("sat_255",     {24'd0, drop_cnt}, 32'd255);
    chk("sat_overrun", {31'd0, overrun},  32'd1);
    chk("sat_hdr",     {24'd0, tx_data},  32'hA1);
    chk("sat_valid",   {31'd0, tx_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spike_frame_tx.md
# spike_frame_tx

- Streams each timestep's 96-neuron spike vector off-chip as a byte-wide framed packet.
- The host-facing transmit end of the spike-readout interface: the neuron array produces a spike vector, and this block serializes it onto `uo_out` using a four-phase valid/ack handshake.
- The host's ack arrives on a `uio_in` pin.
- Sits between the neuron array core and the top-level pin mux of `tt_um_multi_neurons_brosnanyuen`.

## Interface

Parameters:
- `N_NEURONS`, 96: spike vector width; must be a multiple of 8.
- `SYNC_STAGES`, 2: synchronizer depth on `tx_ack`.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `ena` in 1: design enable; new frames are captured only while high.
- `spike_vec` in 96: spike bits from the neuron array; bit i is neuron i.
- `spike_valid` in 1: one-cycle pulse marking end of timestep; `spike_vec` is valid in the same cycle.
- `tx_ack` in 1: host acknowledge; asynchronous pin input.
- `tx_data` out 8: current byte, drives `uo_out`.
- `tx_valid` out 1: byte-present strobe, drives `uio_out[0]`.
- `frame_busy` out 1: high from capture until the last byte is acknowledged.
- `overrun` out 1: sticky flag, set when a frame is dropped.
- `drop_cnt` out 8: count of dropped frames, saturating.

## Operation

- Frame: 14 bytes, sent as index 0..13.
  - Byte 0 is the header: `{4'hA, seq[3:0]}`.
  - Bytes 1..12 are data: byte k = captured `spike_vec[8k-1 : 8k-8]`, LSB neuron first.
  - Byte 13 is the checksum: XOR of bytes 1..12. The header is excluded.
- `seq` is a 4-bit counter, incremented when a frame's last byte completes. It wraps 15 -> 0.
- Capture: if `spike_valid && ena` is seen in IDLE, `spike_vec` is copied into a 96-bit shadow register and the frame starts. Later changes on `spike_vec` do not affect the frame in flight.
- `tx_ack` passes through a `SYNC_STAGES`-flop synchronizer. The FSM sees only the synchronized value, `ack_s`.
- FSM states:
  - IDLE:
    - `tx_valid`=0, `frame_busy`=0.
    - Capture -> PRESENT with idx=0.
  - PRESENT:
    - `tx_valid`=1; `tx_data`=byte[idx] and is held stable.
    - `ack_s`=1 -> WAIT_LOW, and `tx_valid` drops on the next cycle.
  - WAIT_LOW:
    - `tx_valid`=0, `tx_data` holds its last value.
    - `ack_s`=0 and idx<13 -> PRESENT with idx+1.
    - `ack_s`=0 and idx=13 -> IDLE, and `seq` increments.
- Drop rule: `spike_valid` arriving while not in IDLE sets `overrun`=1 and increments `drop_cnt` (saturating at 255). The frame in flight is not disturbed.
- Exception to the drop rule: `spike_valid && ena` in the same cycle as the WAIT_LOW -> IDLE transition is accepted, not dropped. It captures the new vector and goes directly to PRESENT with idx=0. The new frame's header carries the incremented `seq`.
- `spike_valid` with `ena`=0 in IDLE is ignored: no capture and no drop count.
- `ena` falling mid-frame does not abort the frame.
- `overrun` and `drop_cnt` clear only on reset.

## Timing

- Reset (`rst_n`=0 at a clock edge), on the following cycle:
  - `tx_valid`=0, `tx_data`=0x00, `frame_busy`=0, `overrun`=0, `drop_cnt`=0.
  - `seq`=0, idx=0, shadow=0, synchronizer flops=0, state=IDLE.
- Reset mid-frame aborts immediately. No partial byte completion.
- Capture latency: `spike_valid` at edge t gives `tx_valid`=1 and `tx_data`=header from cycle t+1. `frame_busy`=1 from cycle t+1.
- Ack latency: a `tx_ack` rise on the pin at edge t is seen as `ack_s`=1 at edge t+`SYNC_STAGES`. `tx_valid` is 0 the cycle after that.
- The falling edge of `tx_ack` has the same latency; the next byte is presented one cycle after `ack_s`=0 is seen.
- Minimum per-byte period with an instantly responding host: 2×(`SYNC_STAGES`+1) cycles.
- `tx_data` changes only on a WAIT_LOW -> PRESENT or IDLE -> PRESENT transition. It never changes while `tx_valid`=1.
- If `tx_ack` is already high when PRESENT is entered, the byte is taken as acknowledged after the synchronizer delay. Hosts must not do this; the block tolerates it.

## Test plan

- Single frame:
  - Stimulus: `spike_vec`=96'h0123_4567_89AB_CDEF_0011_2233 with one `spike_valid` pulse; host acks each byte with 3-cycle high and 3-cycle low phases.
  - Required: 14 bytes A0, 33, 22, 11, 00, EF, CD, AB, 89, 67, 45, 23, 01, checksum 0x00; `frame_busy` falls after the last ack-low.
- Seq wrap:
  - Stimulus: send 17 frames of all-zero spikes.
  - Required: headers A0..AF, then A0; every data byte 0x00; checksum 0x00.
- Overrun:
  - Stimulus: pulse `spike_valid` 3 times during frame 0.
  - Required: `overrun`=1, `drop_cnt`=3; frame 0 contents unchanged; after 300 more drops, `drop_cnt` stays at 255.
- Boundary acceptance:
  - Stimulus: `spike_valid` in the exact cycle of the last WAIT_LOW -> IDLE transition.
  - Required: no drop counted; the next frame starts with header A1 on the following cycle.
- Stalled host and reset:
  - Stimulus: hold `tx_ack`=0 for 50 cycles at byte 5, then assert `rst_n`=0 for one cycle.
  - Required: `tx_data` is stable for all 50 cycles; after reset all outputs are 0 and the next frame header is A0.
- Enable gating:
  - Stimulus: `spike_valid` with `ena`=0 in IDLE.
  - Required: no frame starts, `drop_cnt` unchanged.
